// File: rtl/burst_pkg.sv
`default_nettype none
// burst_pkg: state encoding, default widths and burst-size helper shared by the burst target.
package burst_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int CNT_W      = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_RECV = 3'd1,
    RD_LOAD = 3'd2,
    RD_SEND = 3'd3,
    DONE    = 3'd4
  } state_t;

  // A programmed burst size of zero behaves as single-beat bursts.
  function automatic logic [CNT_W-1:0] eff_burst(input logic [CNT_W-1:0] size);
    return (size == '0) ? CNT_W'(1) : size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/burst_mem.sv
`default_nettype none
// burst_mem: DEPTH x DATA_W buffer, synchronous write, registered read that holds when not enabled.
module burst_mem
  import burst_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the output register is reset; the array contents are left as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/burst_target.sv
`default_nettype none
// burst_target: far-end responder of the valid/ready/last burst interface with last-framing check.
module burst_target
  import burst_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic              cfg_rw,
  input  logic [7:0]        cfg_length,
  input  logic [7:0]        cfg_burst_size,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done,
  output logic              err_last
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  remaining;
  logic [CNT_W-1:0]  bcnt;
  logic [CNT_W-1:0]  bsize;
  logic              exp_last;
  logic              wr_hs;
  logic              rd_hs;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_raddr;

  // The current beat closes a burst either at the burst boundary or at the end of the transaction.
  assign exp_last = (bcnt == CNT_W'(1)) | (remaining == CNT_W'(1));
  assign wr_hs    = wr_valid & wr_ready;
  assign rd_hs    = rd_valid & rd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;
    rd_last   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    mem_re    = 1'b0;
    mem_raddr = addr + ADDR_W'(1);
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (cfg_start) begin
          if (cfg_length == '0) begin
            state_nxt = DONE;
          end else if (cfg_rw) begin
            state_nxt = WR_RECV;
          end else begin
            state_nxt = RD_LOAD;
          end
        end
      end
      WR_RECV: begin
        wr_ready = 1'b1;
        if (wr_valid && (remaining == CNT_W'(1))) begin
          state_nxt = DONE;
        end
      end
      RD_LOAD: begin
        mem_re    = 1'b1;
        mem_raddr = '0;
        state_nxt = RD_SEND;
      end
      RD_SEND: begin
        rd_valid = 1'b1;
        rd_last  = exp_last;
        // Prefetch the next beat on each handshake so a held rd_ready streams one beat per cycle.
        if (rd_ready) begin
          mem_re = 1'b1;
          if (remaining == CNT_W'(1)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
      bcnt      <= '0;
      bsize     <= CNT_W'(1);
      err_last  <= 1'b0;
    end else if ((state == IDLE) && cfg_start) begin
      addr      <= '0;
      remaining <= cfg_length;
      bsize     <= eff_burst(cfg_burst_size);
      bcnt      <= eff_burst(cfg_burst_size);
      err_last  <= 1'b0;
    end else if (wr_hs || rd_hs) begin
      addr      <= addr + ADDR_W'(1);
      remaining <= remaining - CNT_W'(1);
      bcnt      <= (bcnt == CNT_W'(1)) ? bsize : bcnt - CNT_W'(1);
      if (wr_hs && (wr_last != exp_last)) begin
        err_last <= 1'b1;
      end
    end
  end

  burst_mem #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (wr_hs),
    .waddr(addr),
    .wdata(wr_data),
    .re   (mem_re),
    .raddr(mem_raddr),
    .rdata(rd_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_burst_target.sv
`default_nettype none
// tb_burst_target: directed write/read bursts against hand-computed data, last and timing values.
module tb_burst_target;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_start = 1'b0;
  logic       cfg_rw = 1'b0;
  logic [7:0] cfg_length = '0;
  logic [7:0] cfg_burst_size = '0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_last = 1'b0;
  logic       wr_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_last;
  logic       rd_ready = 1'b0;
  logic       busy;
  logic       done;
  logic       err_last;

  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int d0;
  int err_at;

  always #5 clk = ~clk;

  burst_target dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_start     (cfg_start),
    .cfg_rw        (cfg_rw),
    .cfg_length    (cfg_length),
    .cfg_burst_size(cfg_burst_size),
    .wr_valid      (wr_valid),
    .wr_data       (wr_data),
    .wr_last       (wr_last),
    .wr_ready      (wr_ready),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_last       (rd_last),
    .rd_ready      (rd_ready),
    .busy          (busy),
    .done          (done),
    .err_last      (err_last)
  );

  always @(posedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic start_txn(input logic rw, input logic [7:0] len, input logic [7:0] bs);
    @(negedge clk);
    cfg_start = 1'b1; cfg_rw = rw; cfg_length = len; cfg_burst_size = bs;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic write_beats(input int n, input logic [7:0] base, input logic [15:0] lastv,
                             output int first_err);
    int acc = 0;
    first_err = -1;
    for (int cyc = 0; cyc < 4 * n + 8 && acc < n; cyc++) begin
      if (err_last && first_err < 0) first_err = acc;
      wr_valid = 1'b1;
      wr_data  = base + 8'(acc);
      wr_last  = lastv[acc];
      if (wr_ready) acc++;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    if (err_last && first_err < 0) first_err = acc;
    check("wr_beats", acc, n);
    check("wr_done", done, 1);
    check("wr_ready_in_done", wr_ready, 0);
  endtask

  task automatic read_beats(input int n, input logic [7:0] base, input logic [15:0] lastv,
                            input bit toggle);
    int k = 0;
    int first = -1;
    for (int cyc = 0; cyc < 4 * n + 8 && k < n; cyc++) begin
      rd_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (rd_valid) begin
        if (first < 0) first = cyc;
        check("rd_data", rd_data, 32'(base) + k);
        check("rd_last", rd_last, lastv[k]);
        if (rd_ready) k++;
      end
      @(negedge clk);
    end
    rd_ready = 1'b0;
    check("rd_beats", k, n);
    check("rd_first_valid", first, 1);
    check("rd_valid_end", rd_valid, 0);
    check("rd_done", done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err_last", err_last, 0);
    check("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write 5 beats, bursts of 2, correct framing.
    d0 = done_cnt;
    start_txn(1'b1, 8'd5, 8'd2);
    write_beats(5, 8'h11, 16'h001A, err_at);
    @(negedge clk);
    check("w1_busy", busy, 0);
    check("w1_err", err_last, 0);
    check("w1_done_cnt", done_cnt - d0, 1);

    // Read them back at full rate, then with rd_ready toggling.
    d0 = done_cnt;
    start_txn(1'b0, 8'd5, 8'd2);
    read_beats(5, 8'h11, 16'h001A, 1'b0);
    @(negedge clk);
    check("r1_busy", busy, 0);
    check("r1_done_cnt", done_cnt - d0, 1);
    start_txn(1'b0, 8'd5, 8'd2);
    read_beats(5, 8'h11, 16'h001A, 1'b1);
    @(negedge clk);

    // Misframed write: last on beat 2 of a 4-beat burst.
    d0 = done_cnt;
    start_txn(1'b1, 8'd4, 8'd4);
    write_beats(4, 8'h21, 16'h0002, err_at);
    check("w2_err_at", err_at, 2);
    @(negedge clk);
    check("w2_err_sticky", err_last, 1);
    check("w2_done_cnt", done_cnt - d0, 1);

    // Zero length completes at once and clears the sticky error.
    start_txn(1'b1, 8'd0, 8'd3);
    check("z_done", done, 1);
    check("z_wr_ready", wr_ready, 0);
    check("z_err_clr", err_last, 0);
    @(negedge clk);
    check("z_done_low", done, 0);
    check("z_wr_ready2", wr_ready, 0);
    check("z_busy", busy, 0);

    // All four misframed beats were still stored.
    start_txn(1'b0, 8'd4, 8'd4);
    read_beats(4, 8'h21, 16'h0008, 1'b0);
    @(negedge clk);

    // Burst size 0 acts as 1: every beat is last.
    start_txn(1'b0, 8'd3, 8'd0);
    read_beats(3, 8'h21, 16'h0007, 1'b0);
    @(negedge clk);

    // Reset during beat 3 of an 8-beat read.
    start_txn(1'b1, 8'd8, 8'd8);
    write_beats(8, 8'h31, 16'h0080, err_at);
    check("w3_no_err", err_at, 32'hFFFF_FFFF);
    @(negedge clk);
    d0 = done_cnt;
    start_txn(1'b0, 8'd8, 8'd8);
    rd_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_beat3", rd_data, 8'h33);
    check("rst_mid_valid_pre", rd_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", rd_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_rd_data", rd_data, 0);
    rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_no_done", done_cnt - d0, 0);
    @(negedge clk);
    start_txn(1'b0, 8'd2, 8'd1);
    read_beats(2, 8'h31, 16'h0003, 1'b0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
